// File: rtl/program_memory_loader.sv
// Instruction store for the 8-bit core: serves fetches in RUN and takes byte-stream program loads.
// Build option: define PROGMEM_CHECKSUM_EN to keep a running XOR of the stored bytes on load_checksum.
//
// state  | meaning
// CLEAR  | sweeping FILL_WORD into every word, core held
// RUN    | core released, one-clock registered fetch
// LOAD   | core held, accepting load bytes at wptr
module program_memory_loader #(
    parameter int         ADDR_W    = 8,
    parameter int         DEPTH     = 256,
    parameter logic [7:0] FILL_WORD = 8'hC0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instruction_address,
    output logic [7:0]        instruction,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow,
    output logic [7:0]        load_checksum
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  clr_ptr_q;
    logic [IDX_W:0]    wptr_q;
    logic [ADDR_W:0]   count_q;
    logic              ovf_q;
    logic              hold_q;
    logic              ready_q;
    logic [7:0]        instr_q;
    logic [7:0]        mem_q [DEPTH];

    logic              beat;
    logic              store;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [7:0]        mem_wdata;

    // wptr MSB set means wptr == DEPTH: every further byte is dropped
    assign beat  = load_valid & ready_q;
    assign store = beat & ~wptr_q[IDX_W];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = FILL_WORD;
        if (reset) begin
            case (state_q)
                ST_CLEAR: mem_we = 1'b1;
                ST_LOAD: begin
                    if (store) begin
                        mem_we    = 1'b1;
                        mem_waddr = wptr_q[IDX_W-1:0];
                        mem_wdata = load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            hold_q    <= 1'b1;
            ready_q   <= 1'b0;
            instr_q   <= FILL_WORD;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + IDX_W'(1);
                    if (&clr_ptr_q) begin
                        state_q <= ST_RUN;
                        hold_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    instr_q <= mem_q[instruction_address[IDX_W-1:0]];
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        hold_q  <= 1'b1;
                        ready_q <= 1'b1;
                        instr_q <= FILL_WORD;
                        wptr_q  <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        if (store) begin
                            wptr_q  <= wptr_q + (IDX_W+1)'(1);
                            count_q <= count_q + (ADDR_W+1)'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        if (load_last) begin
                            state_q <= ST_RUN;
                            hold_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    hold_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PROGMEM_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            csum_q <= 8'h00;
        end else if (state_q == ST_RUN && load_start) begin
            csum_q <= 8'h00;
        end else if (state_q == ST_LOAD && store) begin
            csum_q <= csum_q ^ load_data;
        end
    end

    assign load_checksum = csum_q;
`else
    assign load_checksum = 8'h00;
`endif

    assign instruction   = instr_q;
    assign cpu_hold      = hold_q;
    assign load_ready    = ready_q;
    assign load_count    = count_q;
    assign load_overflow = ovf_q;

endmodule
